pe_operand_feeder: RTL and testbench
====================================

# pe_operand_feeder

Sequencer that drives one float16 multiply-accumulate processing element for a single filter output. It holds a TAPS-entry sample window and a TAPS-entry coefficient set, clears the PE accumulator, then streams one (sample, coefficient) pair per cycle. After the last pair it captures the PE sum and presents it on a valid/ready output port. It sits between the window/coefficient loaders and the PE.

## Interface
- DATA_WIDTH, 16, float16 operand/result width
- TAPS, 9, pairs per output (1..2^ADDR_WIDTH)
- ADDR_WIDTH, 4, write address width; 2^ADDR_WIDTH >= TAPS
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state returns to reset values immediately
- smp_we / smp_addr / smp_data  in  1 / ADDR_WIDTH / DATA_WIDTH  sample window write port
- coef_we / coef_addr / coef_data  in  1 / ADDR_WIDTH / DATA_WIDTH  coefficient write port
- start  in  1  single-cycle request to compute one output
- busy  out  1  high whenever state != IDLE
- pe_clear  out  1  registered; drives the PE reset
- pe_floatA  out  DATA_WIDTH  registered sample operand to PE
- pe_floatB  out  DATA_WIDTH  registered coefficient operand to PE
- pe_result  in  DATA_WIDTH  PE accumulator output
- out_valid  out  1  result available
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  captured result

## Operation
- States: IDLE, CLEAR, FEED, CAPTURE, HOLD.
- IDLE: start=1 -> CLEAR. start is ignored in every other state.
- CLEAR (1 cycle): pe_clear=1, operands 0x0000 -> FEED, idx=0.
- FEED (TAPS cycles): pe_floatA=smp[idx], pe_floatB=coef[idx], idx increments. After idx=TAPS-1 -> CAPTURE.
- CAPTURE (1 cycle): operands 0x0000. pe_result is final. On the exiting edge, out_data<=pe_result and out_valid<=1 -> HOLD.
- HOLD: out_valid and out_data stay stable until out_valid&out_ready at an edge, then out_valid<=0 -> IDLE.
- Outside FEED the operands are 0x0000. The PE accumulates +0 and its sum does not change.
- Writes with addr >= TAPS are ignored. Writes while busy=1 are dropped, so the window and coefficients stay frozen during a computation.
- Reset values: pe_clear=1, busy=0, out_valid=0, pe_floatA=pe_floatB=out_data=0x0000, state IDLE, idx=0, both arrays all 0x0000.
- pe_clear falls on the first edge after reset release and is low in IDLE.
- Reset mid-operation aborts the computation: no out_valid, arrays zeroed, PE cleared.
- If out_valid&out_ready and start are high in the same cycle, start is ignored because busy is still 1.

## Timing
- Edge E0 samples start. Cycle 1 is CLEAR. Cycles 2..TAPS+1 are FEED. Cycle TAPS+2 is CAPTURE. out_valid goes high in cycle TAPS+3.
- Latency from start to out_valid is TAPS+3 cycles (12 for TAPS=9).
- Minimum start-to-start period is TAPS+4 cycles with out_ready held high.
- busy falls in the cycle after the accepting handshake edge.

## Configuration
- FEEDER_RELU_EN defined: at capture, out_data = pe_result[15] ? 0x0000 : pe_result. Negative values and -0 become +0.
- FEEDER_RELU_EN undefined: out_data = pe_result unmodified.

## Structure
- Shared package contents:
  - state enum
  - FP16_ZERO constant (0x0000)
  - FP16_SIGN_BIT index (15)
- Sub-module feeder_regfile:
  - TAPS x DATA_WIDTH array with async reset, gated write port and combinational read by idx.
  - Instantiated twice: samples and coefficients.

## Test plan
- Reset asserted -> pe_clear=1, busy=0, out_valid=0, pe_floatA/B=0x0000, out_data=0x0000. Release -> pe_clear=0 one edge later.
- All 9 samples 0x3C00 and all coefs 0x3C00, start -> out_valid in cycle 12, out_data=0x4880 (9.0). pe_floatA/B carry 0x3C00 for exactly 9 cycles.
- Samples 0x3C00, coefs 0xBC00 -> out_data=0xC880 without FEEDER_RELU_EN, 0x0000 with it.
- out_ready low for 5 cycles in HOLD -> out_valid and out_data stable; start pulses during this time produce no new run. out_ready=1 -> busy=0 next cycle.
- coef[0]<=0x4000 written during FEED -> result still 0x4880. Same write in IDLE, then rerun -> 0x4900 (10.0).
- Reset asserted in FEED cycle 5 -> busy=0, no out_valid, pe_clear=1. Reload all ones and start -> 0x4880 with nominal timing.

Source files
------------

// File: rtl/pe_operand_feeder_pkg.sv
// Shared types and constants for the float16 PE operand feeder.
package pe_operand_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    CAPTURE,
    HOLD
  } feederState_e;

  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam int          FP16_SIGN_BIT = 15;

endpackage

// File: rtl/feeder_regfile.sv
// TAPS-entry operand store: async-clear array, gated write, combinational read.
module feeder_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH:0] TapsCount = (ADDR_WIDTH + 1)'(TAPS);

  logic [DATA_WIDTH-1:0] mem [TAPS];
  logic                  writeInRange;
  logic                  readInRange;

  assign writeInRange = ({1'b0, waddr} < TapsCount);
  assign readInRange  = ({1'b0, raddr} < TapsCount);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && writeInRange) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = readInRange ? mem[raddr] : '0;

endmodule

// File: rtl/pe_operand_feeder.sv
// Sequences one filter output through a float16 MAC PE: clear, feed TAPS pairs, capture, hold.
// Optional FEEDER_RELU_EN clamps negative captured results (including -0) to +0.
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  smp_we,
  input  logic [ADDR_WIDTH-1:0] smp_addr,
  input  logic [DATA_WIDTH-1:0] smp_data,
  input  logic                  coef_we,
  input  logic [ADDR_WIDTH-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  pe_clear,
  output logic [DATA_WIDTH-1:0] pe_floatA,
  output logic [DATA_WIDTH-1:0] pe_floatB,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(TAPS - 1);

  feederState_e          state, nextState;
  logic [ADDR_WIDTH-1:0] idx, nextIdx;
  logic [DATA_WIDTH-1:0] smpRd, coefRd, capValue;

  assign busy = (state != IDLE);

  // Arrays freeze while busy so a running computation sees a stable window.
  feeder_regfile #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS), .ADDR_WIDTH(ADDR_WIDTH)) smpFile (
    .clk(clk), .reset(reset), .we(smp_we & ~busy), .waddr(smp_addr), .wdata(smp_data),
    .raddr(nextIdx), .rdata(smpRd)
  );

  feeder_regfile #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS), .ADDR_WIDTH(ADDR_WIDTH)) coefFile (
    .clk(clk), .reset(reset), .we(coef_we & ~busy), .waddr(coef_addr), .wdata(coef_data),
    .raddr(nextIdx), .rdata(coefRd)
  );

`ifdef FEEDER_RELU_EN
  assign capValue = pe_result[FP16_SIGN_BIT] ? FP16_ZERO : pe_result;
`else
  assign capValue = pe_result;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    case (state)
      IDLE:    if (start) nextState = CLEAR;
      CLEAR: begin
        nextState = FEED;
        nextIdx   = '0;
      end
      FEED: begin
        if (idx == LastIdx) begin
          nextState = CAPTURE;
          nextIdx   = '0;
        end else begin
          nextIdx = idx + 1'b1;
        end
      end
      CAPTURE: nextState = HOLD;
      HOLD:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // PE-facing outputs are registered from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_clear  <= 1'b1;
      pe_floatA <= FP16_ZERO;
      pe_floatB <= FP16_ZERO;
      out_valid <= 1'b0;
      out_data  <= FP16_ZERO;
    end else begin
      pe_clear  <= (nextState == CLEAR);
      pe_floatA <= (nextState == FEED) ? smpRd  : FP16_ZERO;
      pe_floatB <= (nextState == FEED) ? coefRd : FP16_ZERO;
      if (state == CAPTURE) begin
        out_valid <= 1'b1;
        out_data  <= capValue;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder with a behavioural float16 MAC PE and result model.
module tb_pe_operand_feeder;

  localparam int DW   = 16;
  localparam int TAPS = 9;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          smp_we, coef_we, start, out_ready;
  logic [AW-1:0] smp_addr, coef_addr;
  logic [DW-1:0] smp_data, coef_data;
  logic          busy, pe_clear, out_valid;
  logic [DW-1:0] pe_floatA, pe_floatB, pe_result, out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] refSmp  [TAPS];
  logic [15:0] refCoef [TAPS];
  real         peAcc;

  pe_operand_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .smp_we(smp_we), .smp_addr(smp_addr), .smp_data(smp_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start(start), .busy(busy), .pe_clear(pe_clear),
    .pe_floatA(pe_floatA), .pe_floatB(pe_floatB), .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic real fp16ToReal(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(int'(h[9:0])) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] realToFp16(input real v);
    real        m;
    int         e;
    logic       s;
    logic [9:0] man;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    man = 10'($rtoi((m - 1.0) * 1024.0));
    return {s, 5'(e + 15), man};
  endfunction

  // Dot product of the window and coefficients as the filter output should read.
  function automatic logic [15:0] modelResult();
    real         sum;
    logic [15:0] r;
    sum = 0.0;
    for (int i = 0; i < TAPS; i++) sum = sum + fp16ToReal(refSmp[i]) * fp16ToReal(refCoef[i]);
    r = realToFp16(sum);
`ifdef FEEDER_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  // Behavioural MAC processing element sitting downstream of the feeder.
  always @(posedge clk or posedge reset) begin
    if (reset || pe_clear) peAcc <= 0.0;
    else peAcc <= peAcc + fp16ToReal(pe_floatA) * fp16ToReal(pe_floatB);
  end
  assign pe_result = realToFp16(peAcc);

  task automatic applyWrite(input logic [AW-1:0] sAddr, input logic [15:0] sData,
                            input logic [AW-1:0] cAddr, input logic [15:0] cData);
    smp_we = 1'b1; smp_addr = sAddr; smp_data = sData;
    coef_we = 1'b1; coef_addr = cAddr; coef_data = cData;
    if (int'(sAddr) < TAPS) refSmp[sAddr] = sData;
    if (int'(cAddr) < TAPS) refCoef[cAddr] = cData;
    @(negedge clk);
    smp_we = 1'b0; coef_we = 1'b0;
  endtask

  task automatic loadAll(input logic [15:0] s, input logic [15:0] c);
    for (int i = 0; i < TAPS; i++) applyWrite(AW'(i), s, AW'(i), c);
  endtask

  task automatic runAndCheck(input string name, input logic [15:0] expected,
                             input int holdCycles, input bit midWrite);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      vectors++;
      if (cyc == 1) begin
        if ({busy, pe_clear, pe_floatA, pe_floatB} !== {1'b1, 1'b1, 32'h0}) begin
          miscompares++;
          $display("[TB] FAIL %s clear cycle: busy/clr/A/B=%b/%b/%h/%h want 1/1/0000/0000",
                   name, busy, pe_clear, pe_floatA, pe_floatB);
        end
      end else if (cyc <= TAPS + 1) begin
        if ({busy, pe_clear, pe_floatA, pe_floatB} !== {1'b1, 1'b0, refSmp[cyc-2], refCoef[cyc-2]}) begin
          miscompares++;
          $display("[TB] FAIL %s feed cycle %0d: busy/clr/A/B=%b/%b/%h/%h want 1/0/%h/%h",
                   name, cyc, busy, pe_clear, pe_floatA, pe_floatB, refSmp[cyc-2], refCoef[cyc-2]);
        end
      end else begin
        if ({busy, pe_clear, pe_floatA, pe_floatB} !== {1'b1, 1'b0, 32'h0}) begin
          miscompares++;
          $display("[TB] FAIL %s capture cycle %0d: busy/clr/A/B=%b/%b/%h/%h want 1/0/0000/0000",
                   name, cyc, busy, pe_clear, pe_floatA, pe_floatB);
        end
      end
      if (midWrite && cyc == 4) begin
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'h4000;
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    coef_we = 1'b0;
    vectors++;
    if (cyc != TAPS + 3 || out_valid !== 1'b1 || out_data !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s result: cycle=%0d valid=%b data=%h want cycle=%0d valid=1 data=%h",
               name, cyc, out_valid, out_data, TAPS + 3, expected);
    end
    for (int h = 0; h < holdCycles; h++) begin
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy, out_valid, out_data} !== {1'b1, 1'b1, expected}) begin
        miscompares++;
        $display("[TB] FAIL %s hold %0d: busy/valid/data=%b/%b/%h want 1/1/%h",
                 name, h, busy, out_valid, out_data, expected);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL %s handshake: busy/valid=%b/%b want 0/0", name, busy, out_valid);
    end
    if (holdCycles > 0) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s start-in-hold ignored: busy=%b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pe_clear, busy, out_valid, pe_floatA, pe_floatB, out_data} !== {3'b100, 48'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset values: clr/busy/valid/A/B/out=%b/%b/%b/%h/%h/%h want 1/0/0/0000/0000/0000",
               pe_clear, busy, out_valid, pe_floatA, pe_floatB, out_data);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (pe_clear !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset release hold: pe_clear=%b want 1", pe_clear);
    end
    @(negedge clk);
    vectors++;
    if ({pe_clear, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset release fall: clr/busy=%b/%b want 0/0", pe_clear, busy);
    end
  endtask

  task automatic test_all_ones();
    loadAll(16'h3C00, 16'h3C00);
    runAndCheck("allOnes", 16'h4880, 0, 1'b0);
  endtask

  task automatic test_negative();
    loadAll(16'h3C00, 16'hBC00);
`ifdef FEEDER_RELU_EN
    runAndCheck("negative", 16'h0000, 0, 1'b0);
`else
    runAndCheck("negative", 16'hC880, 0, 1'b0);
`endif
  endtask

  task automatic test_hold_backpressure();
    loadAll(16'h3C00, 16'h3C00);
    runAndCheck("holdStable", 16'h4880, 5, 1'b0);
  endtask

  task automatic test_write_during_feed();
    runAndCheck("frozenCoef", 16'h4880, 0, 1'b1);
    applyWrite(AW'(TAPS), 16'h5000, AW'(0), 16'h4000);
    runAndCheck("idleCoefWrite", 16'h4900, 0, 1'b0);
  endtask

  task automatic test_reset_mid_feed();
    loadAll(16'h3C00, 16'h3C00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, out_valid, pe_clear, pe_floatA, pe_floatB, out_data} !== {3'b001, 48'h0}) begin
      miscompares++;
      $display("[TB] FAIL midFeedReset: busy/valid/clr/A/B/out=%b/%b/%b/%h/%h/%h want 0/0/1/0000/0000/0000",
               busy, out_valid, pe_clear, pe_floatA, pe_floatB, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) begin refSmp[i] = 16'h0; refCoef[i] = 16'h0; end
    @(negedge clk);
    runAndCheck("zeroedArrays", 16'h0000, 0, 1'b0);
    loadAll(16'h3C00, 16'h3C00);
    runAndCheck("afterReset", 16'h4880, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 6; iter++) begin
      for (int w = 0; w < 12; w++) begin
        applyWrite(AW'($urandom_range(15)), realToFp16(real'(int'($urandom_range(6)) - 3)),
                   AW'($urandom_range(15)), realToFp16(real'(int'($urandom_range(6)) - 3)));
      end
      runAndCheck("random", modelResult(), (iter == 2) ? 3 : 0, iter[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    smp_we = 1'b0; coef_we = 1'b0; start = 1'b0; out_ready = 1'b0;
    smp_addr = '0; coef_addr = '0; smp_data = '0; coef_data = '0;
    for (int i = 0; i < TAPS; i++) begin refSmp[i] = 16'h0; refCoef[i] = 16'h0; end
    test_reset();
    test_all_ones();
    test_negative();
    test_hold_backpressure();
    loadAll(16'h3C00, 16'h3C00);
    test_write_during_feed();
    test_reset_mid_feed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
